pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It takes the load-use hazard operands from ID/EX, the branch/jump resolution from ID and the data-memory handshake from MEM. It drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB enable and flush controls. It replaces the ad-hoc combinational stall logic in the decode stage and adds a bounded memory-wait freeze with timeout detection.

## Interface
Parameters:
- TIMEOUT, 16, maximum consecutive freeze cycles per memory access (≥2)
- CNT_W, 32, width of performance counters

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- MemRead_ex  in  1  instruction in EX is a load
- rdAddr_ex  in  5  destination register of the EX instruction
- rs1Addr_id, rs2Addr_id  in  5 each  source registers of the ID instruction
- rs1Used_id, rs2Used_id  in  1 each  the ID instruction actually reads rs1 / rs2
- Branch_id  in  1  conditional branch taken, resolved in ID
- Jump_id  in  1  JAL/JALR in ID
- DMemReq_mem  in  1  MEM stage instruction accesses data memory this cycle
- DMemReady  in  1  data memory completes the access this cycle
- PCWrite  out  1  PC register enable
- IFWrite  out  1  IF/ID register enable
- IFFlush  out  1  clear IF/ID to NOP at next edge
- IDEXFlush  out  1  load bubble (all controls 0) into ID/EX at next edge
- PipeFreeze  out  1  hold EX/MEM and MEM/WB (their enables = ~PipeFreeze)
- Stall  out  1  load-use stall active this cycle
- MemTimeout  out  1  sticky: a memory access exceeded TIMEOUT
- StallCnt  out  CNT_W  cycles with PCWrite=0
- FlushCnt  out  CNT_W  redirect (flush) events

## Operation
- Hazard: LoadUse = MemRead_ex & (rdAddr_ex≠0) & ((rs1Used_id & rdAddr_ex==rs1Addr_id) | (rs2Used_id & rdAddr_ex==rs2Addr_id)).
- Redirect = (Branch_id | Jump_id) & ~LoadUse & ~Freeze. A branch whose operand is still being loaded is not taken during the stall; it re-resolves the next cycle.
- Freeze (internal) = memory-wait condition, defined per state below.
- Priority: Freeze > LoadUse > Redirect.
  - Freeze: PCWrite=0, IFWrite=0, IFFlush=0, IDEXFlush=0, PipeFreeze=1, Stall=0.
  - LoadUse: PCWrite=0, IFWrite=0, IDEXFlush=1, IFFlush=0.
  - Redirect: PCWrite=1, IFWrite=1, IFFlush=1.
  - None: PCWrite=IFWrite=1, all flushes 0, PipeFreeze=0.
- FSM states: RUN, MEM_WAIT. wait_cnt is ceil(log2(TIMEOUT+1)) bits.
  - RUN: Freeze = DMemReq_mem & ~DMemReady. If Freeze, go to MEM_WAIT and set wait_cnt=1. Otherwise stay in RUN.
  - MEM_WAIT: Freeze = ~DMemReady & (wait_cnt < TIMEOUT).
    - If DMemReady: go to RUN.
    - Else if wait_cnt==TIMEOUT: release (Freeze=0), set MemTimeout, go to RUN.
    - Else: wait_cnt+1.
- Total freeze per access ≤ TIMEOUT cycles. The access is forced through on the release cycle regardless of data validity.
- MemTimeout stays set until reset.
- Counters (when compiled in) saturate nowhere and wrap modulo 2^CNT_W.

## Timing
- All outputs except MemTimeout, StallCnt and FlushCnt are combinational (Mealy) from the inputs and the registered state. They act in the same cycle the hazard is visible.
- Load-use costs exactly one bubble: after the edge the load is in MEM and ID/EX holds a bubble, so LoadUse drops without extra state.
- Redirect costs one cycle: the IF/ID slot is flushed at the edge where PC loads JumpAddr.
- A memory wait completing in n cycles (n ≤ TIMEOUT) freezes for n−1 cycles. DMemReady in the first request cycle gives zero freeze.
- Reset (asynchronous, any time including mid-MEM_WAIT): state=RUN, wait_cnt=0, MemTimeout=0, StallCnt=FlushCnt=0. With idle inputs, PCWrite=IFWrite=1, and IFFlush, IDEXFlush, PipeFreeze and Stall are all 0.
- LoadUse and DMemReq_mem in the same cycle: freeze only. The load-use condition is re-evaluated once the freeze lifts, since ID/EX is held.

## Configuration
- PERF_CNT_EN defined: StallCnt increments on every cycle with PCWrite=0; FlushCnt increments on every cycle with IFFlush=1.
- PERF_CNT_EN undefined: no counter flops; StallCnt and FlushCnt are tied to 0. All other behaviour is identical.

## Test plan
- Load x5 in EX, ID reads rs2=x5 with rs2Used_id=1 → one cycle PCWrite=0, IFWrite=0, IDEXFlush=1, Stall=1. The next cycle is clean. StallCnt=1.
- Load x0 in EX, ID reads x0 → no stall. Load x7 with rs1Used_id=0 but rs1Addr_id=7 → no stall.
- Branch_id=1 with no hazard → IFFlush=1 and PCWrite=1 in that cycle, FlushCnt=1. Branch_id=1 coincident with LoadUse → IFFlush=0, Stall=1.
- DMemReq_mem=1 and DMemReady low for 3 cycles, then high → PipeFreeze=1 for exactly 3 cycles, FSM returns to RUN, MemTimeout=0.
- TIMEOUT=4, DMemReady never asserted → PipeFreeze high for 4 cycles, released on the 5th. MemTimeout=1 after that edge and stays 1.
- Assert reset in the 2nd MEM_WAIT cycle → immediately PipeFreeze=0, state RUN, counters 0, MemTimeout 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubble, branch redirect and a
// bounded memory-wait freeze with sticky timeout. Define PERF_CNT_EN to build the counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemRead_ex,
    input  logic [4:0]       rdAddr_ex,
    input  logic [4:0]       rs1Addr_id,
    input  logic [4:0]       rs2Addr_id,
    input  logic             rs1Used_id,
    input  logic             rs2Used_id,
    input  logic             Branch_id,
    input  logic             Jump_id,
    input  logic             DMemReq_mem,
    input  logic             DMemReady,
    output logic             PCWrite,
    output logic             IFWrite,
    output logic             IFFlush,
    output logic             IDEXFlush,
    output logic             PipeFreeze,
    output logic             Stall,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    localparam int unsigned WaitW = $clog2(TIMEOUT + 1);
    localparam logic [WaitW-1:0] TimeoutVal = WaitW'(TIMEOUT);

    typedef enum logic [0:0] {
        StRun,
        StMemWait
    } state_e;

    state_e           state_q, state_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic             mem_timeout_q, mem_timeout_d;

    logic load_use;
    logic freeze;
    logic redirect;

    assign load_use = MemRead_ex && (rdAddr_ex != 5'd0) &&
                      ((rs1Used_id && (rdAddr_ex == rs1Addr_id)) ||
                       (rs2Used_id && (rdAddr_ex == rs2Addr_id)));

    // wait_cnt counts freeze cycles already spent on the current access.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        freeze        = 1'b0;
        case (state_q)
            StRun: begin
                if (DMemReq_mem && !DMemReady) begin
                    freeze     = 1'b1;
                    state_d    = StMemWait;
                    wait_cnt_d = WaitW'(1);
                end
            end
            StMemWait: begin
                if (DMemReady) begin
                    state_d    = StRun;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q >= TimeoutVal) begin
                    // Force the access through; the pipeline may consume stale data.
                    mem_timeout_d = 1'b1;
                    state_d       = StRun;
                    wait_cnt_d    = '0;
                end else begin
                    freeze     = 1'b1;
                    wait_cnt_d = wait_cnt_q + WaitW'(1);
                end
            end
            default: begin
                state_d    = StRun;
                wait_cnt_d = '0;
            end
        endcase
    end

    assign redirect = (Branch_id || Jump_id) && !load_use && !freeze;

    always_comb begin
        PCWrite    = 1'b1;
        IFWrite    = 1'b1;
        IFFlush    = 1'b0;
        IDEXFlush  = 1'b0;
        PipeFreeze = 1'b0;
        Stall      = 1'b0;
        if (freeze) begin
            PCWrite    = 1'b0;
            IFWrite    = 1'b0;
            PipeFreeze = 1'b1;
        end else if (load_use) begin
            PCWrite   = 1'b0;
            IFWrite   = 1'b0;
            IDEXFlush = 1'b1;
            Stall     = 1'b1;
        end else if (redirect) begin
            IFFlush = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StRun;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign MemTimeout = mem_timeout_q;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!PCWrite) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (IFFlush) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
`else
    assign StallCnt = '0;
    assign FlushCnt = '0;
`endif

endmodule
